// File: rtl/pin_array_pkg.sv
// Purpose: shared types and default sizing for the pin-array sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pin_array_pkg;

  // Default build of the sweep controller
  localparam int DEF_NBITS       = 4;
  localparam int DEF_SETTLE_CYC  = 8;
  localparam int DEF_AVG_SAMPLES = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Width helpers for the default build
  localparam int CODE_W   = DEF_NBITS;
  localparam int MAP_W    = 2 ** DEF_NBITS;
  localparam int SETTLE_W = $clog2(DEF_SETTLE_CYC + 1);
  localparam int SAMP_W   = $clog2(DEF_AVG_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Bits needed to hold a counter reaching maxval (never less than 1)
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/pin_array_sync.sv
// Purpose: multi-flop synchronizer bringing the pin-array vout into the clk domain.
// Latency: STAGES clk cycles from a stable input to q.
// Backpressure: none; free-running every cycle.
module pin_array_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the asynchronous input through the flop chain; reset clears the whole chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pin_array_sweep_ctrl.sv
// Purpose: sweeps the pin-array vin code, majority-votes synchronized vout per code, returns a transfer map.
// Latency: result_valid rises 2**NBITS*(SETTLE_CYC+AVG_SAMPLES) cycles after the start-accept edge.
// Backpressure: result held with result_valid until result_ready; start ignored until back in IDLE.
module pin_array_sweep_ctrl
  import pin_array_pkg::*;
#(
  parameter int NBITS       = DEF_NBITS,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int AVG_SAMPLES = DEF_AVG_SAMPLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [NBITS-1:0]    vin_code,
  input  logic                vout_async,
  output logic                busy,
  output logic [2**NBITS-1:0] result,
  output logic                result_valid,
  input  logic                result_ready
);

  localparam int CW = NBITS;
  localparam int MW = 2 ** NBITS;
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int AW = cnt_w(AVG_SAMPLES);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [AW-1:0] SAMP_LAST   = AW'(AVG_SAMPLES - 1);
  localparam logic [CW-1:0] CODE_MAX    = '1;
  // Majority threshold compared against 2*ones, so ties resolve to 0
  localparam logic [AW+1:0] MAJ_LIMIT   = (AW+2)'(AVG_SAMPLES);

  state_e          state;
  state_e          state_nxt;
  logic [CW-1:0]   code_q;
  logic [SW-1:0]   settle_cnt;
  logic [AW-1:0]   samp_cnt;
  logic [AW-1:0]   ones_cnt;
  logic [MW-1:0]   result_q;
  logic            vout_sync;

  logic            settle_end;
  logic            samp_end;
  logic            code_last;
  logic [AW-1:0]   ones_final;
  logic            maj_bit;

  pin_array_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vout_async),
    .q     (vout_sync)
  );

  assign settle_end = (settle_cnt == SETTLE_LAST);
  assign samp_end   = (samp_cnt == SAMP_LAST);
  assign code_last  = (code_q == CODE_MAX);
  // Count including the sample taken in the current cycle
  assign ones_final = ones_cnt + AW'(vout_sync);
  assign maj_bit    = ({1'b0, ones_final, 1'b0} > MAJ_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)        state_nxt = SETTLE;
        SETTLE:  if (settle_end)   state_nxt = SAMPLE;
        SAMPLE:  if (samp_end)     state_nxt = code_last ? DONE : SETTLE;
        DONE:    if (result_ready) state_nxt = IDLE;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  // Sweep datapath: code stepping, settle/sample timing, vote accumulation and map build-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones_cnt   <= '0;
      result_q   <= '0;
    end else if (abort) begin
      // Drop any partial map so an aborted sweep never looks like a result
      code_q     <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones_cnt   <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            code_q     <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            ones_cnt   <= '0;
            result_q   <= '0;
          end
        end
        SETTLE: begin
          if (settle_end) begin
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (samp_end) begin
            result_q[code_q] <= maj_bit;
            samp_cnt         <= '0;
            ones_cnt         <= '0;
            // Last code parks vin back at 0 as the sweep finishes; otherwise step up
            code_q           <= code_last ? '0 : code_q + 1'b1;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
            ones_cnt <= ones_final;
          end
        end
        default: begin
          // DONE: map and code held while waiting for the consumer
        end
      endcase
    end
  end

  assign vin_code     = code_q;
  assign busy         = (state == SETTLE) || (state == SAMPLE);
  assign result       = result_q;
  assign result_valid = (state == DONE);

endmodule
